// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants and the per-axis phase type.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int H_ACT_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;
    localparam int V_ACT_DEF  = 480;
    localparam int V_FP_DEF   = 10;

    localparam int H_TOTAL = H_SYNC_DEF + H_BP_DEF + H_ACT_DEF + H_FP_DEF;
    localparam int V_TOTAL = V_SYNC_DEF + V_BP_DEF + V_ACT_DEF + V_FP_DEF;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BACK   = 2'd1,
        ACTIVE = 2'd2,
        FRONT  = 2'd3
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_if
// Description : Raster position, sync and active-window bundle of the generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic             pix_ce;
    logic [CNT_W-1:0] out_cnt_x;
    logic [CNT_W-1:0] out_cnt_y;
    logic             hsync;
    logic             vsync;
    logic             disp_active;
    logic             frame_start;

    modport master (
        output pix_ce, out_cnt_x, out_cnt_y, hsync, vsync, disp_active, frame_start
    );

    modport slave (
        input pix_ce, out_cnt_x, out_cnt_y, hsync, vsync, disp_active, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/vga_axis_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_cnt
// Description : One raster axis: wrapping position counter plus SYNC/BACK/
//               ACTIVE/FRONT phase FSM. Reset parks it on the last position.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_cnt
    import vga_timing_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_advance,
    input  wire logic [CNT_W-1:0] i_sync_w,
    input  wire logic [CNT_W-1:0] i_bp_w,
    input  wire logic [CNT_W-1:0] i_act_w,
    input  wire logic [CNT_W-1:0] i_fp_w,
    output logic      [CNT_W-1:0] o_count,
    output phase_t                o_phase,
    output phase_t                o_phase_step,
    output logic                  o_wrap
);

    logic [CNT_W-1:0] r_count;
    phase_t           r_phase;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_count_inc;
    phase_t           w_phase_step;

    assign w_last      = i_sync_w + i_bp_w + i_act_w + i_fp_w - CNT_W'(1);
    assign o_wrap      = (r_count == w_last);
    assign w_count_inc = o_wrap ? '0 : r_count + CNT_W'(1);

    // Phase the axis enters if it advances now: boundary compares use the next count.
    always_comb begin
        w_phase_step = r_phase;
        case (r_phase)
            SYNC:   if (w_count_inc == i_sync_w)                      w_phase_step = BACK;
            BACK:   if (w_count_inc == i_sync_w + i_bp_w)             w_phase_step = ACTIVE;
            ACTIVE: if (w_count_inc == i_sync_w + i_bp_w + i_act_w)   w_phase_step = FRONT;
            FRONT:  if (w_count_inc == '0)                            w_phase_step = SYNC;
            default:                                                  w_phase_step = FRONT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= w_last;
            r_phase <= FRONT;
        end else if (i_advance) begin
            r_count <= w_count_inc;
            r_phase <= w_phase_step;
        end
    end

    assign o_count      = r_count;
    assign o_phase      = r_phase;
    assign o_phase_step = w_phase_step;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator; counts, syncs and active flag are
//               all registered on the same edge. Macro VGA_TIMING_PIXDIV_EN
//               runs the pixel strobe at half the clock rate.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int H_ACT  = H_ACT_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF,
    parameter int V_ACT  = V_ACT_DEF,
    parameter int V_FP   = V_FP_DEF
)(
    input  wire logic    clk,
    input  wire logic    rst,
    vga_timing_if.master vga
);

    logic             r_pix_ce;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_disp_active;
    logic             r_frame_start;
    logic             w_v_adv;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [CNT_W-1:0] w_h_count;
    logic [CNT_W-1:0] w_v_count;
    phase_t           w_h_phase;
    phase_t           w_v_phase;
    phase_t           w_h_step;
    phase_t           w_v_step;
    phase_t           w_h_ph_nxt;
    phase_t           w_v_ph_nxt;

`ifdef VGA_TIMING_PIXDIV_EN
    always_ff @(posedge clk) begin
        if (rst) r_pix_ce <= 1'b0;
        else     r_pix_ce <= ~r_pix_ce;
    end
`else
    always_ff @(posedge clk) begin
        if (rst) r_pix_ce <= 1'b0;
        else     r_pix_ce <= 1'b1;
    end
`endif

    assign w_v_adv = r_pix_ce & w_h_wrap;

    vga_axis_cnt u_h_axis (
        .clk          (clk),
        .rst          (rst),
        .i_advance    (r_pix_ce),
        .i_sync_w     (CNT_W'(H_SYNC)),
        .i_bp_w       (CNT_W'(H_BP)),
        .i_act_w      (CNT_W'(H_ACT)),
        .i_fp_w       (CNT_W'(H_FP)),
        .o_count      (w_h_count),
        .o_phase      (w_h_phase),
        .o_phase_step (w_h_step),
        .o_wrap       (w_h_wrap)
    );

    vga_axis_cnt u_v_axis (
        .clk          (clk),
        .rst          (rst),
        .i_advance    (w_v_adv),
        .i_sync_w     (CNT_W'(V_SYNC)),
        .i_bp_w       (CNT_W'(V_BP)),
        .i_act_w      (CNT_W'(V_ACT)),
        .i_fp_w       (CNT_W'(V_FP)),
        .o_count      (w_v_count),
        .o_phase      (w_v_phase),
        .o_phase_step (w_v_step),
        .o_wrap       (w_v_wrap)
    );

    // Flags are registered from next-state phases so they line up with the counts.
    assign w_h_ph_nxt = r_pix_ce ? w_h_step : w_h_phase;
    assign w_v_ph_nxt = w_v_adv  ? w_v_step : w_v_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_disp_active <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= (w_h_ph_nxt != SYNC);
            r_vsync       <= (w_v_ph_nxt != SYNC);
            r_disp_active <= (w_h_ph_nxt == ACTIVE) && (w_v_ph_nxt == ACTIVE);
            r_frame_start <= r_pix_ce ? (w_h_wrap & w_v_wrap) : r_frame_start;
        end
    end

    assign vga.pix_ce      = r_pix_ce;
    assign vga.out_cnt_x   = w_h_count;
    assign vga.out_cnt_y   = w_v_count;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.disp_active = r_disp_active;
    assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench: default-timing DUT plus a tiny-timing DUT
//               for whole-frame and mid-frame reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic       ce;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
    } obs_t;

    typedef struct {
        int   d;
        obs_t e;
    } sb_t;

    typedef struct {
        int   k;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic act;
        logic fs;
    } vec_t;

    localparam int P_HS [2] = '{96, 3};
    localparam int P_HB [2] = '{48, 2};
    localparam int P_HA [2] = '{640, 5};
    localparam int P_HT [2] = '{800, 12};
    localparam int P_VS [2] = '{2, 2};
    localparam int P_VB [2] = '{33, 1};
    localparam int P_VA [2] = '{480, 3};
    localparam int P_VT [2] = '{525, 8};
    localparam int NT = 11;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    vga_timing_if vga_a ();
    vga_timing_if vga_b ();

    vga_timing_gen dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (vga_a.master)
    );

    vga_timing_gen #(
        .H_SYNC (3), .H_BP (2), .H_ACT (5), .H_FP (2),
        .V_SYNC (2), .V_BP (1), .V_ACT (3), .V_FP (2)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (vga_b.master)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   mx [2];
    int   my [2];
    int   adv_cnt [2] = '{0, 0};
    int   trace_err [2] = '{0, 0};
    logic mce [2];
    logic adv [2];
    sb_t  sbq [$];
    vec_t tbl [NT];
    int   ti = 0;
    int   a_hsl = 0, a_act35 = 0, a_first_x = -1;
    int   b_fs = 0, b_act = 0, b_vsl = 0, b_hsl = 0;
    logic b_agg_en = 1'b1;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic obs_t model_out(int d);
        obs_t o;
        o.ce  = mce[d];
        o.x   = 10'(mx[d]);
        o.y   = 10'(my[d]);
        o.hs  = (mx[d] >= P_HS[d]);
        o.vs  = (my[d] >= P_VS[d]);
        o.act = (mx[d] >= P_HS[d] + P_HB[d]) && (mx[d] < P_HS[d] + P_HB[d] + P_HA[d]) &&
                (my[d] >= P_VS[d] + P_VB[d]) && (my[d] < P_VS[d] + P_VB[d] + P_VA[d]);
        o.fs  = (mx[d] == 0) && (my[d] == 0);
        return o;
    endfunction

    function automatic obs_t dut_out(int d);
        obs_t o;
        if (d == 0) begin
            o.ce = vga_a.pix_ce; o.x = vga_a.out_cnt_x; o.y = vga_a.out_cnt_y;
            o.hs = vga_a.hsync; o.vs = vga_a.vsync; o.act = vga_a.disp_active; o.fs = vga_a.frame_start;
        end else begin
            o.ce = vga_b.pix_ce; o.x = vga_b.out_cnt_x; o.y = vga_b.out_cnt_y;
            o.hs = vga_b.hsync; o.vs = vga_b.vsync; o.act = vga_b.disp_active; o.fs = vga_b.frame_start;
        end
        return o;
    endfunction

    // One clock: step the reference model, queue its prediction, compare after the edge.
    task automatic tick();
        obs_t ga, gb, g;
        sb_t  s;
        logic r;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            r = (d == 0) ? rst_a : rst_b;
            if (r) begin
                mx[d] = P_HT[d] - 1; my[d] = P_VT[d] - 1;
                mce[d] = 1'b0; adv[d] = 1'b0; adv_cnt[d] = 0;
            end else begin
                adv[d] = mce[d];
                if (mce[d]) begin
                    adv_cnt[d]++;
                    if (mx[d] == P_HT[d] - 1) begin
                        mx[d] = 0;
                        my[d] = (my[d] == P_VT[d] - 1) ? 0 : my[d] + 1;
                    end else begin
                        mx[d]++;
                    end
                end
`ifdef VGA_TIMING_PIXDIV_EN
                mce[d] = ~mce[d];
`else
                mce[d] = 1'b1;
`endif
            end
            sbq.push_back('{d: d, e: model_out(d)});
        end
        #1;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            g = dut_out(s.d);
            if (g !== s.e) trace_err[s.d]++;
        end
        ga = dut_out(0);
        gb = dut_out(1);
        if (adv[0]) begin
            if (adv_cnt[0] <= 800 && !ga.hs) a_hsl++;
            if (adv_cnt[0] > 28000 && adv_cnt[0] <= 28800 && ga.act) begin
                a_act35++;
                if (a_first_x < 0) a_first_x = int'(ga.x);
            end
            if (ti < NT && adv_cnt[0] == tbl[ti].k) begin
                chk($sformatf("tbl%0d_x", ti),   int'(ga.x),   tbl[ti].x);
                chk($sformatf("tbl%0d_y", ti),   int'(ga.y),   tbl[ti].y);
                chk($sformatf("tbl%0d_hs", ti),  int'(ga.hs),  int'(tbl[ti].hs));
                chk($sformatf("tbl%0d_vs", ti),  int'(ga.vs),  int'(tbl[ti].vs));
                chk($sformatf("tbl%0d_act", ti), int'(ga.act), int'(tbl[ti].act));
                chk($sformatf("tbl%0d_fs", ti),  int'(ga.fs),  int'(tbl[ti].fs));
                ti++;
            end
        end
        if (adv[1] && b_agg_en && adv_cnt[1] <= 96) begin
            b_fs  += int'(gb.fs);
            b_act += int'(gb.act);
            b_vsl += int'(!gb.vs);
            b_hsl += int'(!gb.hs);
        end
    endtask

    initial begin
        int   guard;
        int   pat [4];
        obs_t g;

        // advance index k (1 = first advance after reset) -> expected outputs
        tbl[0]  = '{1,     0,   0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{96,    95,  0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{97,    96,  0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{800,   799, 0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{801,   0,   1,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1601,  0,   2,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{27345, 144, 34, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{28144, 143, 35, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{28145, 144, 35, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{28784, 783, 35, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{28785, 784, 35, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef VGA_TIMING_PIXDIV_EN
        pat = '{0, 1, 0, 1};
`else
        pat = '{0, 1, 1, 1};
`endif

        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) tick();
        g = dut_out(0);
        chk("rst_x", int'(g.x), 799);
        chk("rst_y", int'(g.y), 524);
        chk("rst_hsync", int'(g.hs), 1);
        chk("rst_vsync", int'(g.vs), 1);
        chk("rst_active", int'(g.act), 0);
        chk("rst_fs", int'(g.fs), 0);
        chk("rst_pix_ce", int'(g.ce), 0);
        g = dut_out(1);
        chk("b_rst_x", int'(g.x), 11);
        chk("b_rst_y", int'(g.y), 7);

        rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pix_ce_pat%0d", i), int'(vga_a.pix_ce), pat[i]);
            tick();
        end

        // small DUT: one full frame then the wrap back to (0,0)
        guard = 0;
        while (adv_cnt[1] < 97 && guard < 1000) begin tick(); guard++; end
        chk("b_frame_reach", adv_cnt[1], 97);
        b_agg_en = 1'b0;
        g = dut_out(1);
        chk("b_wrap_x", int'(g.x), 0);
        chk("b_wrap_y", int'(g.y), 0);
        chk("b_wrap_fs", int'(g.fs), 1);
        chk("b_frame_fs", b_fs, 1);
        chk("b_frame_act", b_act, 15);
        chk("b_frame_vsync_low", b_vsl, 24);
        chk("b_frame_hsync_low", b_hsl, 24);

        // small DUT: one-clock reset in mid-frame
        guard = 0;
        while (adv_cnt[1] < 150 && guard < 1000) begin tick(); guard++; end
        chk("b_mid_reach", adv_cnt[1], 150);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        g = dut_out(1);
        chk("b_mid_rst_x", int'(g.x), 11);
        chk("b_mid_rst_y", int'(g.y), 7);
        chk("b_mid_rst_hs", int'(g.hs), 1);
        chk("b_mid_rst_vs", int'(g.vs), 1);
        chk("b_mid_rst_act", int'(g.act), 0);
        chk("b_mid_rst_ce", int'(g.ce), 0);
        guard = 0;
        while (adv_cnt[1] < 1 && guard < 10) begin tick(); guard++; end
        chk("b_post_rst_reach", adv_cnt[1], 1);
        g = dut_out(1);
        chk("b_post_rst_x", int'(g.x), 0);
        chk("b_post_rst_y", int'(g.y), 0);
        chk("b_post_rst_fs", int'(g.fs), 1);
        chk("b_post_rst_hs", int'(g.hs), 0);
        chk("b_post_rst_vs", int'(g.vs), 0);

        // default DUT: run through active line 35
        guard = 0;
        while (adv_cnt[0] < 28800 && guard < 70000) begin tick(); guard++; end
        chk("a_run_reach", adv_cnt[0], 28800);
        chk("a_table_done", ti, NT);
        chk("a_line0_hsync_low", a_hsl, 96);
        chk("a_line35_active", a_act35, 640);
        chk("a_line35_first_x", a_first_x, 144);
        chk("a_trace", trace_err[0], 0);
        chk("b_trace", trace_err[1], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning):
- H_SYNC 96: hsync pulse width, pixels.
- H_BP 48: horizontal back porch.
- H_ACT 640: active pixels per line.
- H_FP 16: horizontal front porch.
- V_SYNC 2: vsync pulse width, lines.
- V_BP 33: vertical back porch.
- V_ACT 480: active lines.
- V_FP 10: vertical front porch.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, all logic on rising edge.
- rst, in, 1: reset, synchronous, active-high.
- pix_ce, out, 1: pixel-advance strobe.
- out_cnt_x, out, 10: raw horizontal count, 0..H_TOTAL-1.
- out_cnt_y, out, 10: raw vertical count, 0..V_TOTAL-1.
- hsync, out, 1: horizontal sync, active-low.
- vsync, out, 1: vertical sync, active-low.
- disp_active, out, 1: high inside the active window.
- frame_start, out, 1: high while the position is (0,0).

Function
REQ-003 Totals: H_TOTAL = sum of H_* parameters (800); V_TOTAL = sum of V_* parameters (525).
REQ-004 Counters advance only on a clk edge where pix_ce=1; otherwise all outputs except pix_ce hold.
REQ-005 out_cnt_x increments by 1 and wraps H_TOTAL-1 -> 0.
REQ-006 out_cnt_y increments only on the same edge that out_cnt_x wraps, and wraps V_TOTAL-1 -> 0 on that edge.
REQ-007 Each axis runs a phase FSM with states SYNC -> BACK -> ACTIVE -> FRONT -> SYNC.
- The transition happens on the advance edge where the next count equals the phase boundary: H_SYNC, H_SYNC+H_BP, H_SYNC+H_BP+H_ACT, and 0 (vertical likewise).
REQ-008 hsync=0 exactly when the horizontal phase is SYNC (out_cnt_x 0..95); vsync=0 exactly when the vertical phase is SYNC (out_cnt_y 0..1).
REQ-009 disp_active=1 exactly when both phases are ACTIVE:
- out_cnt_x 144..783;
- out_cnt_y 35..514.
REQ-010 All outputs are registered and describe the same pixel as the registered out_cnt_x/out_cnt_y; there is zero skew between counts and the sync/active flags.
REQ-011 frame_start=1 for exactly one pixel period (the period in which counts are (0,0)); it is 0 otherwise.
REQ-012 Counts never exceed H_TOTAL-1 / V_TOTAL-1, including across reset.

Reset
REQ-013 While rst=1 at a clk edge, the next state is:
- out_cnt_x=H_TOTAL-1, out_cnt_y=V_TOTAL-1;
- both phases FRONT;
- hsync=1, vsync=1, disp_active=0, frame_start=0, pix_ce=0.
REQ-014 Reset asserted mid-frame overrides any pix_ce on that edge.
REQ-015 The first advance after reset produces (0,0) with frame_start=1, hsync=0 and vsync=0.

Configuration
REQ-016 Macro VGA_TIMING_PIXDIV_EN:
- Defined: clk is twice the pixel rate (50 MHz). pix_ce comes from an internal toggle reset to 0; it is 0 on the first clk after reset release, 1 on the second, then alternates.
- Undefined: clk is the pixel clock and pix_ce=1 on every clk edge after reset release (0 during reset).

Structure
REQ-017 Package vga_timing_pkg holds:
- the default timing constants, H_TOTAL and V_TOTAL;
- the 2-bit phase enum (SYNC, BACK, ACTIVE, FRONT).
REQ-018 Sub-module vga_axis_cnt implements one counter plus its phase FSM, with inputs advance and the four widths, and outputs count, phase and wrap. It is instantiated twice:
- horizontal, advanced by pix_ce;
- vertical, advanced by pix_ce AND horizontal wrap.

Verification
REQ-019 Release rst with PIXDIV defined -> pix_ce pattern 0,1,0,1; first advance gives cnt (0,0), frame_start=1, hsync=0, vsync=0.
REQ-020 Run one line -> hsync low for exactly 96 advances; disp_active high for 640 advances starting at x=144; x wraps 799 -> 0 and y increments on that same edge.
REQ-021 Run one full frame -> 525 lines, 420000 advances; vsync low on lines 0-1 only; disp_active high for exactly 307200 advances; frame_start high for exactly 1 pixel period.
REQ-022 Corner (799,524) -> next advance gives (0,0) with frame_start=1 and hsync/vsync both falling on the same edge.
REQ-023 Assert rst for 1 clk at (500,200) -> next cycle shows (799,524), hsync=1, vsync=1, disp_active=0; the following advance gives (0,0).
REQ-024 PIXDIV undefined -> pix_ce=1 every cycle; one full frame completes in 420000 clk cycles.
